// File: rtl/stream_fifo_pkg.sv
// Shared constants and width helpers for stream_fifo.
// Pure compile-time content: no latency, no flow control.
package stream_fifo_pkg;

  localparam int BUF_DEPTH = 2;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int cnt_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/rw_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data is valid one edge after the read is issued; no flow control.
module rw_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter     RAM_TYPE   = "auto"
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Register-file builds read every cycle; RAM macros only on request.
  generate
    if (RAM_TYPE == "registers") begin : g_free_run
      always_ff @(posedge clk) r_rd_data <= r_mem[rd_addr];
    end else begin : g_gated
      always_ff @(posedge clk) begin
        if (rd_en) r_rd_data <= r_mem[rd_addr];
      end
    end
  endgenerate

  assign rd_data = r_rd_data;

endmodule

// File: rtl/stream_fifo_outbuf.sv
// 2-entry in-order output queue; head is registered, load and pop may coincide.
// Caller must not load when full without popping; flush wins over load/pop.
module stream_fifo_outbuf import stream_fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [1:0]            occ,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] r_data [BUF_DEPTH];
  logic [1:0]            r_occ;
  logic                  w_pop;

  assign w_pop = pop && (r_occ != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ     <= 2'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else if (flush) begin
      r_occ     <= 2'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else begin
      case ({load, w_pop})
        2'b01: begin
          r_data[0] <= r_data[1];
          r_occ     <= r_occ - 2'd1;
        end
        2'b10: begin
          if (r_occ == 2'd0) r_data[0] <= load_data;
          else               r_data[1] <= load_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (r_occ == 2'd1) begin
            r_data[0] <= load_data;
          end else begin
            r_data[0] <= r_data[1];
            r_data[1] <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ        = r_occ;
  assign head_valid = (r_occ != 2'd0);
  assign head_data  = r_data[0];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO: RAM storage + 2-entry output buffer, DEPTH+2 words, 1 word/cycle.
// Push-to-m_valid latency 2 edges; s_ready tracks RAM full only. STREAM_FIFO_COUNT_EN adds count.
module stream_fifo import stream_fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter     RAM_TYPE   = "auto"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef STREAM_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH+1:0] count
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_rd_pending;
  logic                  r_s_ready;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic                  w_full_nxt;
  logic                  w_ram_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fetch;
  logic [1:0]            w_occ;
  logic                  w_head_valid;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [DATA_WIDTH-1:0] w_ram_rd_data;

  assign w_push      = s_valid && r_s_ready;
  assign w_pop       = w_head_valid && m_ready;
  assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
  // Fetch only if the word will still have a buffer slot when it lands.
  assign w_fetch     = !w_ram_empty &&
                       (({1'b0, w_occ} + {2'b00, r_rd_pending}) < (3'd2 + {2'b00, w_pop}));

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (clear) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_push)  w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      if (w_fetch) w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end
  end

  assign w_full_nxt = (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]) &&
                      (w_wr_ptr_nxt[PW-2:0] == w_rd_ptr_nxt[PW-2:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_pending <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_rd_pending <= w_fetch && !clear;
      r_s_ready    <= !w_full_nxt;
    end
  end

  rw_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_TYPE   (RAM_TYPE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_push && !clear),
    .wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (s_data),
    .rd_en   (w_fetch && !clear),
    .rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (w_ram_rd_data)
  );

  stream_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (r_rd_pending),
    .load_data  (w_ram_rd_data),
    .pop        (w_pop),
    .flush      (clear),
    .occ        (w_occ),
    .head_valid (w_head_valid),
    .head_data  (w_head_data)
  );

  assign s_ready = r_s_ready;
  assign m_valid = w_head_valid;
  assign m_data  = w_head_data;

`ifdef STREAM_FIFO_COUNT_EN
  localparam int CW = cnt_width(ADDR_WIDTH);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign count = r_count;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: reset, latency, fill/drain, streaming, clear, async reset.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
`ifdef STREAM_FIFO_COUNT_EN
  logic [5:0] count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .RAM_TYPE   ("auto")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef STREAM_FIFO_COUNT_EN
    ,
    .count   (count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    tick(); tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
`ifdef STREAM_FIFO_COUNT_EN
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
`endif
    reset_n = 1'b1;
    #2;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL release_s_ready_early: got %b expected 0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b expected 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL release_m_valid: got %b expected 0", m_valid); end
`ifdef STREAM_FIFO_COUNT_EN
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL release_count: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_single();
    s_data = 8'hA5; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_lat_n0: got %b expected 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_lat_n1: got %b expected 0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_lat_n2: got %b expected 1", m_valid); end
    checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", m_data); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b expected 0", m_valid); end
`ifdef STREAM_FIFO_COUNT_EN
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL single_count: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_fill();
    int accepted;
    int idx;
    accepted = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_data = 8'(i); s_valid = 1'b1;
      if (s_ready) accepted++;
      tick();
    end
    s_valid = 1'b0;
    repeat (4) tick();
    checks++; if (accepted != 18) begin errors++; $display("FAIL fill_accepted: got %0d expected 18", accepted); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h00) begin errors++; $display("FAIL fill_head: got %b/%h expected 1/00", m_valid, m_data); end
`ifdef STREAM_FIFO_COUNT_EN
    checks++; if (count !== 6'd18) begin errors++; $display("FAIL fill_count: got %0d expected 18", count); end
`endif
    m_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 100 && idx < 18; c++) begin
      if (m_valid) begin
        checks++; if (m_data !== idx[7:0]) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", idx, m_data, idx[7:0]); end
        idx++;
      end
      tick();
    end
    checks++; if (idx != 18) begin errors++; $display("FAIL drain_words: got %0d expected 18", idx); end
    repeat (3) tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL drain_s_ready: got %b expected 1", s_ready); end
`ifdef STREAM_FIFO_COUNT_EN
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_back_to_back();
    int sent;
    int exp;
    int first;
    int last;
    sent = 0; exp = 0; first = -1; last = -1;
    m_ready = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (sent < 100) begin s_data = 8'(sent); s_valid = 1'b1; end
      else s_valid = 1'b0;
      if (m_valid) begin
        checks++; if (m_data !== exp[7:0]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", exp, m_data, exp[7:0]); end
        exp++;
        if (first < 0) first = c;
        last = c;
      end
      if (s_valid && s_ready) sent++;
      tick();
    end
    s_valid = 1'b0;
    checks++; if (exp != 100) begin errors++; $display("FAIL stream_words: got %0d expected 100", exp); end
    checks++; if (first != 3) begin errors++; $display("FAIL stream_first_cycle: got %0d expected 3", first); end
    checks++; if (last != 102) begin errors++; $display("FAIL stream_last_cycle: got %0d expected 102", last); end
  endtask

  task automatic test_clear();
    int seen;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'h10 + 8'(i); s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    clear = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    tick();
    clear = 1'b0; s_valid = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL clear_m_valid: got %b expected 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL clear_s_ready: got %b expected 1", s_ready); end
`ifdef STREAM_FIFO_COUNT_EN
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", count); end
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL clear_stale[%0d]: got %b expected 0", k, m_valid); end
    end
    s_data = 8'h3C; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (m_valid) begin
        checks++; if (m_data !== 8'h3C) begin errors++; $display("FAIL clear_first_word: got %h expected 3c", m_data); end
        seen = 1;
      end
      tick();
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL clear_word_timeout: got %0d expected 1", seen); end
    repeat (3) tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL clear_after_empty: got %b expected 0", m_valid); end
  endtask

  task automatic test_async_reset();
    int stale;
    int seen;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'h80 + 8'(i); s_valid = 1'b1;
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL arst_s_ready: got %b expected 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL arst_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL arst_m_data: got %h expected 00", m_data); end
`ifdef STREAM_FIFO_COUNT_EN
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
`endif
    s_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL arst_release_s_ready: got %b expected 1", s_ready); end
    stale = 0;
    repeat (6) begin
      if (m_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL arst_stale_words: got %0d expected 0", stale); end
    s_data = 8'h5A; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (m_valid) begin
        checks++; if (m_data !== 8'h5A) begin errors++; $display("FAIL arst_first_word: got %h expected 5a", m_data); end
        seen = 1;
      end
      tick();
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL arst_word_timeout: got %0d expected 1", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Valid/ready streaming FIFO for inter-core message and DMA paths. Storage is a `rw_port_ram` instance with a registered read and 1-cycle read latency. Control logic adds the pointers and full/empty tracking that the RAM lacks. A 2-entry output buffer hides the read latency, so the FIFO sustains one word per cycle on both ports.

## Interface
- `DATA_WIDTH`, 8: word width.
- `ADDR_WIDTH`, 4: RAM address width; RAM depth `DEPTH = 1 << ADDR_WIDTH`.
- `RAM_TYPE`, "auto": passed unchanged to the storage RAM.
- `clk` in 1: single clock; all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush.
- `s_data` in DATA_WIDTH: input word.
- `s_valid` in 1: input word present.
- `s_ready` out 1: FIFO can accept.
- `m_data` out DATA_WIDTH: head word.
- `m_valid` out 1: head word present.
- `m_ready` in 1: consumer takes the head word.
- `count` out ADDR_WIDTH+2: occupancy. Present only with the configuration macro.

## Operation
- Push: `s_valid & s_ready` at an edge. Pop: `m_valid & m_ready` at an edge. `s_data` is written at `wr_ptr`, and `wr_ptr` increments.
- `wr_ptr` and `rd_ptr` are each ADDR_WIDTH+1 bits and wrap modulo 2·DEPTH.
  - RAM occupancy: `wr_ptr - rd_ptr`, modulo 2·DEPTH.
  - RAM full: MSBs differ and the low bits are equal.
  - RAM empty: the pointers are equal.
- `s_ready` = not RAM full. It is registered and updated every cycle from next-state pointers.
- Fetch: issue a RAM read at `rd_ptr`, increment `rd_ptr`, and set `rd_pending` for one cycle. A fetch is issued when both hold:
  - RAM is not empty.
  - `buf_occ + rd_pending - pop < 2`.
- When `rd_pending` is set, the RAM output is loaded into the output buffer on the next edge.
- Output buffer is a 2-entry in-order queue. `m_data` and `m_valid` come from entry 0. A pop and a load in the same cycle both take effect.
- The RAM read only ever targets entries written at least one edge earlier. No read-during-write hazard exists.
- Total capacity is DEPTH + 2 words. `s_ready` reflects only the RAM, so the buffer words are extra headroom.
- Push when the RAM is full cannot occur, because `s_ready` = 0. Simultaneous push and pop at any fill level are both honoured.
- `clear` has priority over push, pop and fetch in the same cycle. It:
  - zeroes both pointers,
  - empties the buffer,
  - drops an in-flight `rd_pending`,
  - sets `m_valid` = 0 and `s_ready` = 1 on the next edge.
- RAM contents are not cleared; stale data is never exposed.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `s_ready` = 0, `m_valid` = 0, `m_data` = 0, `count` = 0.
  - Pointers and `rd_pending` = 0.
  - `s_ready` rises on the first edge after release.
- Latency: a word pushed into an empty FIFO at edge N appears with `m_valid` = 1 after edge N+2. Breakdown:
  - read issued in the cycle after N,
  - RAM output at N+1,
  - buffer load at N+2.
- Steady-state throughput is 1 word per cycle with `m_ready` held high.
- `m_data` is stable while `m_valid & !m_ready`.
- Reset asserted mid-transfer discards all contents. Behaviour after release equals a fresh reset.

## Configuration
- `STREAM_FIFO_COUNT_EN` defined:
  - `count` port exists and is registered.
  - Equals pushes minus pops since the last reset or `clear`.
  - Range 0..DEPTH+2.
- `STREAM_FIFO_COUNT_EN` undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `stream_fifo_pkg` holds:
  - `BUF_DEPTH` = 2,
  - pointer width function `ADDR_WIDTH+1`,
  - count width function `ADDR_WIDTH+2`.
- Sub-module `stream_fifo_outbuf` is the 2-entry output queue with load/pop/flush. Its ports are `load`, `load_data`, `pop`, `flush`, `occ`, `head_valid`, `head_data`.
- Storage is one `rw_port_ram` instance with `RAM_TYPE` passed through.

## Test plan
- Reset release, idle: `s_ready` rises one edge after release; `m_valid` = 0 and `count` = 0 throughout.
- Push 0xA5 once at edge N with `m_ready` = 1: `m_valid` = 1 with `m_data` = 0xA5 after edge N+2; popped next edge; `count` back to 0.
- Fill with ADDR_WIDTH=4 and `m_ready` = 0, pushing 0..19:
  - 18 words accepted (16 RAM + 2 buffer), `count` = 18.
  - `s_ready` = 0 once the RAM is full.
  - Drain yields 0..17 in order.
- Continuous stream of 100 incrementing words with `s_valid` = `m_ready` = 1: after a 2-cycle fill, one word out per cycle, no gaps, order preserved across pointer wrap.
- `clear` asserted with 5 words stored and a fetch in flight, plus simultaneous push and pop: next cycle `m_valid` = 0, `count` = 0, `s_ready` = 1; a later push of 0x3C emerges as the first word.
- `reset_n` asserted mid-stream between edges: outputs drop immediately to reset values; no pre-reset word ever appears after release.
